// File: rtl/yuv444_to_422.sv
// 4:4:4 to 4:2:2 chroma subsampler with a small output FIFO; emits {Y0,Cb} then {Y1,Cr}.
// Optional build macro YUV422_ROUND_EN: round-half-up chroma average (default: floor).
module yuv444_to_422 #(
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 16
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_y,
    input  logic [DW-1:0] in_u,
    input  logic [DW-1:0] in_v,
    input  logic          in_eol,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_y,
    output logic [DW-1:0] out_c,
    output logic          out_eol
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef YUV422_ROUND_EN
    localparam logic [DW:0] RND = (DW+1)'(1);
`else
    localparam logic [DW:0] RND = '0;
`endif

    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

    phase_t        r_state;
    logic [DW-1:0] r_y0, r_u0, r_v0;
    logic [DW-1:0] r_fy [FIFO_DEPTH];
    logic [DW-1:0] r_fc [FIFO_DEPTH];
    logic          r_fe [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_free;
    logic          w_xfer, w_push, w_pop;
    logic [DW:0]   w_su, w_sv;
    logic [DW-1:0] w_cb, w_cr;
    logic          w_unused_lsb;
    logic [DW-1:0] w_e0_y, w_e0_c, w_e1_y, w_e1_c;
    logic          w_e1_eol;

    assign w_free   = CW'(FIFO_DEPTH) - r_count;
    assign in_ready = (w_free >= CW'(2));
    assign w_xfer   = in_valid & in_ready;
    assign w_push   = w_xfer & ((r_state == ODD) | in_eol);
    assign w_pop    = out_valid & out_ready;

    // Sign-extended DW+1 sum; taking bits [DW:1] is the arithmetic shift right by one.
    assign w_su         = {r_u0[DW-1], r_u0} + {in_u[DW-1], in_u} + RND;
    assign w_sv         = {r_v0[DW-1], r_v0} + {in_v[DW-1], in_v} + RND;
    assign w_cb         = w_su[DW:1];
    assign w_cr         = w_sv[DW:1];
    assign w_unused_lsb = w_su[0] ^ w_sv[0];

    always_comb begin
        w_e0_y   = in_y;
        w_e0_c   = in_u;
        w_e1_y   = in_y;
        w_e1_c   = in_v;
        w_e1_eol = 1'b1;
        if (r_state == ODD) begin
            w_e0_y   = r_y0;
            w_e0_c   = w_cb;
            w_e1_c   = w_cr;
            w_e1_eol = in_eol;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state  <= EVEN;
            r_y0     <= '0;
            r_u0     <= '0;
            r_v0     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_xfer) begin
                if (r_state == EVEN) begin
                    r_y0 <= in_y;
                    r_u0 <= in_u;
                    r_v0 <= in_v;
                    // A lone pixel at end of line is emitted immediately, so pairing stays EVEN.
                    r_state <= in_eol ? EVEN : ODD;
                end else begin
                    r_state <= EVEN;
                end
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(2);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (w_push ? CW'(2) : '0) - (w_pop ? CW'(1) : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fy[r_wr_ptr]          <= w_e0_y;
            r_fc[r_wr_ptr]          <= w_e0_c;
            r_fe[r_wr_ptr]          <= 1'b0;
            r_fy[r_wr_ptr + AW'(1)] <= w_e1_y;
            r_fc[r_wr_ptr + AW'(1)] <= w_e1_c;
            r_fe[r_wr_ptr + AW'(1)] <= w_e1_eol;
        end
    end

    // Head is masked while empty so outputs read zero after reset.
    assign out_valid = (r_count != '0);
    assign out_y     = out_valid ? r_fy[r_rd_ptr] : '0;
    assign out_c     = out_valid ? r_fc[r_rd_ptr] : '0;
    assign out_eol   = out_valid ? r_fe[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_yuv444_to_422.sv
// Scoreboard bench for yuv444_to_422: stimulus queues expected beats, a monitor pops and compares.
module tb_yuv444_to_422;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_y, in_u, in_v;
    logic        in_eol;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y, out_c;
    logic        out_eol;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] c;
        logic        eol;
    } beat_t;

    beat_t exp_q[$];

    yuv444_to_422 #(.FIFO_DEPTH(4), .DW(16)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_y     (in_y),
        .in_u     (in_u),
        .in_v     (in_v),
        .in_eol   (in_eol),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_c    (out_c),
        .out_eol  (out_eol)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] s;
        s = $signed({a[15], a}) + $signed({b[15], b});
`ifdef YUV422_ROUND_EN
        s = s + 17'sd1;
`endif
        s = s >>> 1;
        return s[15:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_beat(input logic [15:0] y, input logic [15:0] c, input logic eol);
        beat_t b;
        b.y = y; b.c = c; b.eol = eol;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [15:0] y, input logic [15:0] u, input logic [15:0] v,
                        input logic eol);
        int tries;
        in_valid = 1'b1;
        in_y = y; in_u = u; in_v = v; in_eol = eol;
        tries = 0;
        @(negedge clock);
        while (!in_ready && tries < 500) begin
            tries++;
            @(negedge clock);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready actual=0 required=1");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pair(input logic [15:0] y0, input logic [15:0] u0, input logic [15:0] v0,
                        input logic [15:0] y1, input logic [15:0] u1, input logic [15:0] v1,
                        input logic eol);
        expect_beat(y0, avg(u0, u1), 1'b0);
        expect_beat(y1, avg(v0, v1), eol);
        send(y0, u0, v0, 1'b0);
        send(y1, u1, v1, eol);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clock);
            cyc++;
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending beats actual=%0d required=0", exp_q.size());
        end
    endtask

    // Monitor: every accepted output beat is compared against the head of the queue.
    always @(negedge clock) begin
        beat_t act, req;
        if (rst_n && out_valid && out_ready) begin
            act.y = out_y; act.c = out_c; act.eol = out_eol;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: actual={%0h,%0h,%0b} required=none",
                         act.y, act.c, act.eol);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    n_err++;
                    $display("FAIL beat: actual={%0h,%0h,%0b} required={%0h,%0h,%0b}",
                             act.y, act.c, act.eol, req.y, req.c, req.eol);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_y = '0; in_u = '0; in_v = '0; in_eol = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_c", 64'(out_c), 64'd0);
        check("rst_out_eol", 64'(out_eol), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;

        // Single pair: U 10/21, V -4/-7
`ifdef YUV422_ROUND_EN
        expect_beat(16'd100, 16'd16, 1'b0);
        expect_beat(16'd200, 16'hFFFB, 1'b0);
`else
        expect_beat(16'd100, 16'd15, 1'b0);
        expect_beat(16'd200, 16'hFFFA, 1'b0);
`endif
        send(16'd100, 16'd10, 16'hFFFC, 1'b0);
        send(16'd200, 16'd21, 16'hFFF9, 1'b0);
        drain();

        // Extreme chroma must not wrap
        expect_beat(16'd1, 16'h7FFF, 1'b0);
        expect_beat(16'd2, 16'h8000, 1'b0);
        send(16'd1, 16'h7FFF, 16'h8000, 1'b0);
        send(16'd2, 16'h7FFF, 16'h8000, 1'b0);
        drain();

        // Odd-length line of 3, then the next pixel starts a fresh pair
        expect_beat(16'd1, 16'd4, 1'b0);
        expect_beat(16'd3, 16'd6, 1'b0);
        expect_beat(16'd7, 16'd5, 1'b0);
        expect_beat(16'd7, 16'hFFF7, 1'b1);
        expect_beat(16'd10, 16'd1, 1'b0);
        expect_beat(16'd20, 16'd1, 1'b0);
        send(16'd1, 16'd2, 16'd4, 1'b0);
        send(16'd3, 16'd6, 16'd8, 1'b0);
        send(16'd7, 16'd5, 16'hFFF7, 1'b1);
        send(16'd10, 16'd0, 16'd0, 1'b0);
        send(16'd20, 16'd2, 16'd2, 1'b0);
        drain();

        // Backpressure: out_ready low for 5 cycles while streaming 16 pixels
        @(posedge clock); #1;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    pair(16'(i * 74 + 5), 16'(i * 8198 - 30000), 16'(20000 - i * 6002),
                         16'(i * 74 + 42), 16'(i * 4099 - 3), 16'(i * 3001 - 15001),
                         i == 7);
            end
            begin
                repeat (4) @(posedge clock);
                @(negedge clock);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Continuous stream: in_ready never drops, one beat per cycle after the first pair
        fork
            begin
                for (int i = 0; i < 8; i++)
                    pair(16'(i * 3 + 300), 16'(i * 1000 - 4000), 16'(i * 777),
                         16'(i * 3 + 301), 16'(5 - i * 999), 16'(i * 50 - 100), 1'b0);
            end
            begin
                @(posedge clock);
                @(posedge clock);
                for (int k = 0; k < 15; k++) begin
                    @(negedge clock);
                    check("cont_in_ready", 64'(in_ready), 64'd1);
                    check("cont_out_valid", 64'(out_valid), 64'd1);
                end
            end
        join
        drain();

        // Reset with queued beats and a latched even pixel discards everything
        out_ready = 1'b0;
        send(16'd11, 16'd1, 16'd1, 1'b0);
        send(16'd12, 16'd3, 16'd3, 1'b0);
        send(16'd13, 16'd100, 16'd100, 1'b0);
        rst_n = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(negedge clock);
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_out_y", 64'(out_y), 64'd0);
        check("rst2_out_c", 64'(out_c), 64'd0);
        check("rst2_out_eol", 64'(out_eol), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        expect_beat(16'd50, 16'd6, 1'b0);
        expect_beat(16'd60, 16'd8, 1'b0);
        send(16'd50, 16'd4, 16'd6, 1'b0);
        send(16'd60, 16'd8, 16'd10, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
